led_pwm_seq: RTL and testbench

LED_PWM_SEQ -- requirements
Module: led_pwm_seq

---
 rtl/led_pwm_seq.sv | 123 ++++++++++++
 tb/tb_led_pwm_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_seq.sv
// led_pwm_seq: three-channel LED PWM driver with a six-state colour wheel.
// A free-running counter sets the PWM period. Each upstream step strobe
// ramps one channel up or down. Working duties are copied into shadow
// registers only at the period boundary, so a step never produces a
// glitch part-way through a period.
// Optional build macro LED_PWM_GAMMA_EN: the shadow registers hold the
// gamma-corrected duty (d*d)>>PWM_BITS instead of the linear duty.
module led_pwm_seq #(
  parameter int PWM_BITS       = 8,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       step_i,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic [2:0] phase_o
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  typedef enum logic [2:0] {
    G_UP = 3'd0, R_DN = 3'd1, B_UP = 3'd2, G_DN = 3'd3, R_UP = 3'd4, B_DN = 3'd5
  } phase_t;

  phase_t              state;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
  logic [PWM_BITS-1:0] sh_r, sh_g, sh_b;
  logic [PWM_BITS-1:0] act, act_nxt;
  logic                up, hit, period_end;

  assign period_end = (pwm_cnt == MAX);
  assign phase_o    = state;

  // Value loaded into a shadow at the period boundary.
  function automatic logic [PWM_BITS-1:0] shade(input logic [PWM_BITS-1:0] d);
`ifdef LED_PWM_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
    return sq[2*PWM_BITS-1:PWM_BITS];
`else
    return d;
`endif
  endfunction

  // Active channel for the current phase, its saturated next value, and
  // whether this step ends the phase.
  always_comb begin
    act = duty_g;
    up  = 1'b1;
    case (state)
      G_UP:    begin act = duty_g; up = 1'b1; end
      R_DN:    begin act = duty_r; up = 1'b0; end
      B_UP:    begin act = duty_b; up = 1'b1; end
      G_DN:    begin act = duty_g; up = 1'b0; end
      R_UP:    begin act = duty_r; up = 1'b1; end
      B_DN:    begin act = duty_b; up = 1'b0; end
      default: begin act = duty_g; up = 1'b1; end
    endcase
    if (up) act_nxt = (act == MAX) ? MAX : act + 1'b1;
    else    act_nxt = (act == '0)  ? '0  : act - 1'b1;
    hit = up ? (act_nxt == MAX) : (act_nxt == '0);
  end

  // Free-running period counter; it keeps running while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Colour-wheel sequencer: apply the step to the active duty, and advance
  // the phase on the step where that duty reaches its end value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= G_UP;
      duty_r <= MAX;
      duty_g <= '0;
      duty_b <= '0;
    end else if (en && step_i) begin
      case (state)
        G_UP, G_DN: duty_g <= act_nxt;
        R_DN, R_UP: duty_r <= act_nxt;
        default:    duty_b <= act_nxt;
      endcase
      if (hit) state <= (state == B_DN) ? G_UP : phase_t'(state + 3'd1);
    end
  end

  // Shadow load at the period boundary. A step in the same cycle is not
  // seen here because the shadows sample the pre-step duties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r <= MAX;
      sh_g <= '0;
      sh_b <= '0;
    end else if (period_end) begin
      sh_r <= shade(duty_r);
      sh_g <= shade(duty_g);
      sh_b <= shade(duty_b);
    end
  end

  // Registered pins: compare the counter against the shadows, blanked while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= LED_ACTIVE_LOW;
      led_g <= LED_ACTIVE_LOW;
      led_b <= LED_ACTIVE_LOW;
    end else if (!en) begin
      led_r <= LED_ACTIVE_LOW;
      led_g <= LED_ACTIVE_LOW;
      led_b <= LED_ACTIVE_LOW;
    end else begin
      led_r <= (pwm_cnt < sh_r) ^ LED_ACTIVE_LOW;
      led_g <= (pwm_cnt < sh_g) ^ LED_ACTIVE_LOW;
      led_b <= (pwm_cnt < sh_b) ^ LED_ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_led_pwm_seq.sv
// tb_led_pwm_seq: directed bench for led_pwm_seq (PWM_BITS=8, active-low pins).
// Duties are observed as lit-cycle counts over one aligned PWM period.
module tb_led_pwm_seq;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, step_i = 1'b0;
  logic       led_r, led_g, led_b;
  logic [2:0] phase_o;

  int n_cmp = 0, n_bad = 0;

  led_pwm_seq #(.PWM_BITS(8), .LED_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .step_i(step_i),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .phase_o(phase_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int steps;
    int ph;
    int r, g, b;
  } vec_t;

  vec_t tbl [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Lit-cycle count expected for a duty in this build.
  function automatic int exp_lit(input int d);
`ifdef LED_PWM_GAMMA_EN
    return (d * d) >> 8;
`else
    return d;
`endif
  endfunction

  // Step strobe held high for n cycles, then one idle cycle.
  task automatic do_steps(input int n);
    step_i = 1'b1;
    repeat (n) tick();
    step_i = 1'b0;
    tick();
  endtask

  // Wait for the start of a period, then count lit cycles per channel.
  task automatic measure(output int cr, output int cg, output int cb);
    int w;
    w = 0; cr = 0; cg = 0; cb = 0;
    while (dut.pwm_cnt != 8'd0 && w < 300) begin
      tick();
      w++;
    end
    if (w >= 300) chk("sync_timeout", w, 0);
    for (int i = 0; i < 256; i++) begin
      tick();
      cr += (led_r == 1'b0) ? 1 : 0;
      cg += (led_g == 1'b0) ? 1 : 0;
      cb += (led_b == 1'b0) ? 1 : 0;
    end
  endtask

  task automatic wait_cnt(input int v);
    int w;
    w = 0;
    while (dut.pwm_cnt != v[7:0] && w < 300) begin
      tick();
      w++;
    end
    if (w >= 300) chk("cnt_wait_timeout", w, 0);
  endtask

  initial begin
    int cr, cg, cb, bad;

    // steps applied since the previous row, then expected phase and duties
    tbl[0] = '{100, 0, 255, 100,   0};
    tbl[1] = '{155, 1, 255, 255,   0};
    tbl[2] = '{  1, 1, 254, 255,   0};
    tbl[3] = '{254, 2,   0, 255,   0};
    tbl[4] = '{255, 3,   0, 255, 255};
    tbl[5] = '{255, 4,   0,   0, 255};
    tbl[6] = '{255, 5, 255,   0, 255};
    tbl[7] = '{254, 5, 255,   0,   1};
    tbl[8] = '{  1, 0, 255,   0,   0};

    // held in reset with en high: pins unlit, phase 0
    en = 1'b1;
    repeat (3) tick();
    chk("rst_led_r", led_r, 1);
    chk("rst_led_g", led_g, 1);
    chk("rst_led_b", led_b, 1);
    chk("rst_phase", phase_o, 0);
    rst_n = 1'b1;
    tick();

    // free-running with no steps
    measure(cr, cg, cb);
    chk("idle_r", cr, exp_lit(255));
    chk("idle_g", cg, 0);
    chk("idle_b", cb, 0);
    chk("idle_phase", phase_o, 0);

    // one full colour-wheel cycle (1530 steps)
    for (int i = 0; i < 9; i++) begin
      do_steps(tbl[i].steps);
      measure(cr, cg, cb);
      chk($sformatf("tbl%0d_phase", i), phase_o, tbl[i].ph);
      chk($sformatf("tbl%0d_r", i), cr, exp_lit(tbl[i].r));
      chk($sformatf("tbl%0d_g", i), cg, exp_lit(tbl[i].g));
      chk($sformatf("tbl%0d_b", i), cb, exp_lit(tbl[i].b));
    end

    // step in the shadow-load cycle shows up one period later
    do_steps(10);
    wait_cnt(255);
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    measure(cr, cg, cb);
    chk("bnd_first_g", cg, exp_lit(10));
    measure(cr, cg, cb);
    chk("bnd_next_g", cg, exp_lit(11));

    // en low: blanked on the next edge, steps ignored
    en = 1'b0;
    tick();
    chk("en_off_pins", {led_r, led_g, led_b}, 3'b111);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step_i = (i % 2 == 0);
      tick();
      if ({led_r, led_g, led_b} != 3'b111) bad++;
    end
    step_i = 1'b0;
    chk("en_off_blank_cycles", bad, 0);
    wait_cnt(5);
    en = 1'b1;
    tick();
    chk("en_resume_led_r", led_r, 0);
    chk("en_resume_phase", phase_o, 0);
    tick();
    measure(cr, cg, cb);
    chk("en_hold_r", cr, exp_lit(255));
    chk("en_hold_g", cg, exp_lit(11));
    chk("en_hold_b", cb, 0);

    // red at 128: linear vs gamma lit count
    do_steps(244);
    chk("g_full_phase", phase_o, 1);
    do_steps(127);
    measure(cr, cg, cb);
    chk("r128_phase", phase_o, 1);
    chk("r128_lit", cr, exp_lit(128));
    chk("r128_g", cg, exp_lit(255));

    // asynchronous reset mid-sequence
    do_steps(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pins", {led_r, led_g, led_b}, 3'b111);
    chk("mid_rst_phase", phase_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    measure(cr, cg, cb);
    chk("post_rst_phase", phase_o, 0);
    chk("post_rst_r", cr, exp_lit(255));
    chk("post_rst_g", cg, 0);
    chk("post_rst_b", cb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
